// File: rtl/calc_ctrl.sv
// Sequencing controller for the calculator ALU: debounced execute/clear buttons,
// operand/opcode staging, fixed-latency wait and accumulator write-back.
module calc_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnd,
  input  logic        btnu,
  input  logic [3:0]  alu_op_in,
  input  logic [15:0] sw,
  input  logic [31:0] alu_result,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] acc,
  output logic [15:0] led,
  output logic        busy,
  output logic        done
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WB} state_t;

  // Index 0 is the execute button, index 1 the clear button.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_level;
  logic [1:0]      r_evt;
  logic [DB_W-1:0] r_db_cnt [2];

  logic            w_exe_evt;
  logic            w_clr_evt;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_wb_wr;
  logic [3:0]      r_cnt;

  logic [3:0]      r_alu_op;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [31:0]     r_acc;

  assign w_raw = {btnu, btnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_evt   <= '0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // Level flips on the final agreeing sample; only a press yields an event.
          r_db_cnt[i] <= '0;
          r_level[i]  <= ~r_level[i];
          r_evt[i]    <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_exe_evt = r_evt[0];
  assign w_clr_evt = r_evt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_wb_wr = 1'b0;
    case (r_state)
      S_IDLE: if (w_exe_evt) w_next = S_LOAD;
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: if (r_cnt == 4'd0) w_next = S_WB;
      S_WB: begin
        w_wb_wr = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Clear overrides everything, including a same-cycle execute and the write-back.
    if (w_clr_evt) begin
      w_next  = S_IDLE;
      w_load  = 1'b0;
      w_wb_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_acc    <= '0;
    end else begin
      if (w_load)                                   r_cnt <= CNT_INIT;
      else if (r_state == S_EXEC && r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;

      if (w_clr_evt) begin
        r_acc   <= '0;
        r_alu_a <= '0;
        r_alu_b <= '0;
      end else begin
        if (w_load) begin
          r_alu_op <= alu_op_in;
          r_alu_a  <= r_acc;
          r_alu_b  <= {{16{sw[15]}}, sw};
        end
        if (w_wb_wr) r_acc <= alu_result;
      end
    end
  end

  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign acc    = r_acc;
  assign led    = r_acc[15:0];
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_WB) && !w_clr_evt;

endmodule

// File: tb/tb_calc_ctrl.sv
// Randomized scoreboard bench for calc_ctrl: a reference accumulator model predicts
// each write-back; a negedge monitor checks every done pulse against the queue.
module tb_calc_ctrl;

  localparam int D = 4;
  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btnd;
  logic        btnu;
  logic [3:0]  alu_op_in;
  logic [15:0] sw;
  logic [31:0] alu_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] acc;
  logic [15:0] led;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  calc_ctrl #(.DEBOUNCE_CYCLES(D), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .btnd(btnd), .btnu(btnu),
    .alu_op_in(alu_op_in), .sw(sw), .alu_result(alu_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .acc(acc),
    .led(led), .busy(busy), .done(done)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      default: return b ^ {28'h0, op};
    endcase
  endfunction

  // ALU with exactly L cycles of latency: a result is only correct L cycles after its inputs.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_op, alu_a, alu_b);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[L-1];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mac;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each done pulse pop the prediction; the accumulator is checked one cycle later.
  int          blen = 0;
  logic        pend = 1'b0;
  logic [31:0] pres = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      blen = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("acc_wb", acc, pres);
        check("led_wb", {16'h0, led}, {16'h0, pres[15:0]});
        pend = 1'b0;
      end
      if (busy) blen++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("alu_op", {28'h0, alu_op}, {28'h0, e.op});
          check("alu_a", alu_a, e.a);
          check("alu_b", alu_b, e.b);
          check("busy_len", blen, L + 2);
          pend = 1'b1;
          pres = e.res;
        end
      end
      if (!busy) blen = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_op(input logic [3:0] op, input logic [15:0] s);
    exp_t e;
    e.op  = op;
    e.a   = mac;
    e.b   = {{16{s[15]}}, s};
    e.res = alu_f(op, mac, e.b);
    sb.push_back(e);
    mac = e.res;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] s, input int hold);
    alu_op_in = op;
    sw        = s;
    expect_op(op, s);
    btnd = 1'b1;
    tick(hold);
    btnd = 1'b0;
    tick(D + L + 20);
  endtask

  task automatic glitch(input int g);
    logic saw;
    saw  = 1'b0;
    btnd = 1'b1;
    tick(g);
    btnd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) saw = 1'b1;
    end
    check("glitch_no_load", {31'h0, saw}, 32'd0);
  endtask

  // Execute and clear pressed with an offset of delta cycles; any delta up to L+2 aborts.
  task automatic clash(input int delta);
    alu_op_in = 4'($urandom_range(0, 15));
    sw        = 16'($urandom);
    for (int c = 0; c < delta + D + 2; c++) begin
      btnd = (c < D + 2);
      btnu = (c >= delta) && (c < delta + D + 2);
      tick(1);
    end
    btnd = 1'b0;
    btnu = 1'b0;
    mac  = '0;
    tick(D + L + 20);
    check("acc_after_clr", acc, 32'd0);
    check("idle_after_clr", {31'h0, busy}, 32'd0);
  endtask

  // A second press lands 2D..2D+1 cycles after the first, inside the busy window.
  task automatic ignored_exec(input int gap);
    logic [3:0]  op;
    logic [15:0] s;
    op        = 4'($urandom_range(0, 15));
    s         = 16'($urandom);
    alu_op_in = op;
    sw        = s;
    expect_op(op, s);
    btnd = 1'b1;
    tick(D);
    btnd = 1'b0;
    tick(gap);
    btnd = 1'b1;
    tick(D);
    btnd = 1'b0;
    tick(D + L + 20);
  endtask

  task automatic clear_idle();
    btnu = 1'b1;
    tick(D + 1);
    btnu = 1'b0;
    tick(D + 5);
    mac = '0;
    check("acc_clear_idle", acc, 32'd0);
  endtask

  task automatic reset_mid_op();
    logic found;
    found     = 1'b0;
    alu_op_in = 4'd2;
    sw        = 16'($urandom);
    btnd      = 1'b1;
    tick(D + 1);
    btnd = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (busy) found = 1'b1;
    end
    check("busy_seen_before_rst", {31'h0, found}, 32'd1);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    check("rst_mid_acc", acc, 32'd0);
    check("rst_mid_alu_a", alu_a, 32'd0);
    check("rst_mid_alu_b", alu_b, 32'd0);
    check("rst_mid_alu_op", {28'h0, alu_op}, 32'd0);
    sb.delete();
    mac = '0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
  endtask

  initial begin
    int kind;
    rst_n     = 1'b0;
    btnd      = 1'b0;
    btnu      = 1'b0;
    alu_op_in = '0;
    sw        = '0;
    mac       = '0;
    for (int i = 0; i < 10; i++) begin
      btnd = 1'($urandom);
      btnu = 1'($urandom);
      tick(1);
    end
    check("rst_acc", acc, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {28'h0, alu_op}, 32'd0);
    check("rst_led", {16'h0, led}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    btnd = 1'b0;
    btnu = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("idle_busy", {31'h0, busy}, 32'd0);
    check("idle_acc", acc, 32'd0);

    run_op(4'b0010, 16'h0005, D + 2);
    run_op(4'b0010, 16'hFFFF, D + 2);
    glitch(D - 1);
    glitch(1);
    run_op(4'b0010, 16'h1234, 50);
    ignored_exec(D);
    run_op(4'd6, 16'h5678, D + 1);
    clash(0);
    run_op(4'd5, 16'h8001, D + 3);
    clash(3);

    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5)       run_op(4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(D, D + 8));
      else if (kind == 5) glitch($urandom_range(1, D - 1));
      else if (kind == 6) clash($urandom_range(0, L + 2));
      else if (kind == 7) ignored_exec($urandom_range(D, D + 1));
      else if (kind == 8) clear_idle();
      else                run_op(4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(D, D + 40));
    end

    reset_mid_op();
    run_op(4'd2, 16'h00A5, D + 2);
    tick(5);
    check("sb_empty", sb.size(), 32'd0);
    check("final_acc", acc, mac);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
